// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: FSM encoding, instruction layout
// and the op codes forwarded to the external ALU.
package alu_sequencer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int INSTR_W  = 8;
   localparam int OP_W     = 3;
   localparam int OP_LSB   = 5;
   localparam int OPND_W   = 4;
   localparam int OPND_LSB = 1;
   localparam int LAST_BIT = 0;

   localparam logic [2:0] OP_ADD_RC = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b001;
   localparam logic [2:0] OP_SUB    = 3'b010;
   localparam logic [2:0] OP_AND    = 3'b011;
   localparam logic [2:0] OP_OR     = 3'b100;
   localparam logic [2:0] OP_SHL    = 3'b101;
   localparam logic [2:0] OP_MUL    = 3'b110;
   localparam logic [2:0] OP_HOLD   = 3'b111;

   // Field order matches the bit positions above: op in [7:5], operand in [4:1], last in [0].
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [OPND_W-1:0] operand;
      logic              last;
   } instr_t;

   function automatic logic [INSTR_W-1:0] make_instr(input logic [OP_W-1:0] op,
                                                      input logic [OPND_W-1:0] operand,
                                                      input logic last);
      logic [INSTR_W-1:0] w;
      w = '0;
      w[OP_LSB +: OP_W]     = op;
      w[OPND_LSB +: OPND_W] = operand;
      w[LAST_BIT]           = last;
      return w;
   endfunction

endpackage

// File: rtl/alu_sequencer_prog_buf.sv
// Program store: one synchronous write port, one asynchronous read port.
module prog_buf #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   // No reset: contents survive a sequencer reset.
   always_ff @(posedge i_clk) begin
      if (i_we && (32'(i_waddr) < DEPTH)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Steps through a small program, driving an external ALU one instruction
// every two cycles and folding its result back into the accumulator.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter  int PROG_DEPTH     = 8,
   parameter  bit CLEAR_ON_START = 1'b1,
   localparam int AW             = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [7:0]    prog_data,
   input  logic          start,
   input  logic [7:0]    alu_result,
   output logic [2:0]    alu_op,
   output logic [3:0]    alu_a,
   output logic [7:0]    acc,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] LAST_PC = AW'(PROG_DEPTH - 1);

   logic [1:0]    r_state;
   instr_t        r_ir;
   logic [AW-1:0] r_pc;
   logic [7:0]    r_acc;
   logic [7:0]    w_rdata;
   logic          w_we;

   // Programming is only allowed while idle; this also covers a write coinciding with start.
   assign w_we = prog_we && (r_state == ST_IDLE);

   prog_buf #(
      .DEPTH (PROG_DEPTH),
      .AW    (AW)
   ) u_prog_buf (
      .i_clk   (clk),
      .i_we    (w_we),
      .i_waddr (prog_addr),
      .i_wdata (prog_data),
      .i_raddr (r_pc),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_ir    <= '0;
         r_pc    <= '0;
         r_acc   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_FETCH;
                  r_pc    <= '0;
                  if (CLEAR_ON_START) begin
                     r_acc <= '0;
                  end
               end
            end
            ST_FETCH: begin
               r_ir    <= instr_t'(w_rdata);
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               r_acc <= alu_result;
               // pc saturates at the last entry so the run ends instead of wrapping.
               if (r_ir.last || (r_pc == LAST_PC)) begin
                  r_state <= ST_DONE;
               end else begin
                  r_pc    <= r_pc + 1'b1;
                  r_state <= ST_FETCH;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign alu_op = (r_state == ST_EXEC) ? r_ir.op      : OP_HOLD;
   assign alu_a  = (r_state == ST_EXEC) ? r_ir.operand : '0;
   assign acc    = r_acc;
   assign pc     = r_pc;
   assign busy   = (r_state != ST_IDLE);
   assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a scoreboard holds the expected {acc, pc}
// for every run and a monitor pops it on each done pulse.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       prog_we;
   logic [2:0] prog_addr;
   logic [7:0] prog_data;
   logic       start;
   logic       start_nc;
   logic [7:0] alu_result;
   logic [2:0] alu_op;
   logic [3:0] alu_a;
   logic [7:0] acc;
   logic [2:0] pc;
   logic       busy;
   logic       done;
   logic [7:0] alu_result_nc;
   logic [2:0] alu_op_nc;
   logic [3:0] alu_a_nc;
   logic [7:0] acc_nc;
   logic [2:0] pc_nc;
   logic       busy_nc;
   logic       done_nc;

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] exp_q[$];
   logic [10:0] exp_nc_q[$];

   always #5 clk = ~clk;

   alu_sequencer #(.PROG_DEPTH(8), .CLEAR_ON_START(1'b1)) u_dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .alu_result(alu_result),
      .alu_op(alu_op), .alu_a(alu_a), .acc(acc), .pc(pc), .busy(busy), .done(done)
   );

   alu_sequencer #(.PROG_DEPTH(8), .CLEAR_ON_START(1'b0)) u_dut_nc (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start_nc), .alu_result(alu_result_nc),
      .alu_op(alu_op_nc), .alu_a(alu_a_nc), .acc(acc_nc), .pc(pc_nc),
      .busy(busy_nc), .done(done_nc)
   );

   function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                            input logic [7:0] b_acc);
      logic [7:0] r;
      case (op)
         OP_ADD:  r = {4'h0, a} + {4'h0, b_acc[3:0]};
         OP_MUL:  r = {4'h0, a} * {4'h0, b_acc[3:0]};
         OP_SHL:  r = b_acc << a;
         OP_ADD_RC, OP_SUB, OP_AND, OP_OR, OP_HOLD: r = b_acc;
         default: r = b_acc;
      endcase
      return r;
   endfunction

   always_comb alu_result    = alu_model(alu_op, alu_a, acc);
   always_comb alu_result_nc = alu_model(alu_op_nc, alu_a_nc, acc_nc);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected {acc, pc}.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
         else check("done_acc_pc", 32'({acc, pc}), 32'(exp_q.pop_front()));
      end
      if (done_nc === 1'b1) begin
         if (exp_nc_q.size() == 0) check("unexpected_done_nc", 32'(done_nc), 32'd0);
         else check("done_nc_acc_pc", 32'({acc_nc, pc_nc}), 32'(exp_nc_q.pop_front()));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic write_prog(input logic [2:0] addr, input logic [7:0] data);
      @(posedge clk); #1;
      prog_we = 1'b1; prog_addr = addr; prog_data = data;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   task automatic start_run(input bit nc);
      @(posedge clk); #1;
      if (nc) start_nc = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start_nc = 1'b0;
   endtask

   task automatic wait_done(input bit nc, input int max_cycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(nc ? done_nc : done) && n < max_cycles);
      check(nc ? "done_seen_nc" : "done_seen", 32'(nc ? done_nc : done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int exec_cnt;
      reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      start = 1'b0; start_nc = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      step();
      check("rst_acc", 32'(acc), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'(OP_HOLD));
      check("rst_alu_a", 32'(alu_a), 32'd0);

      // Two-instruction add program with cycle-accurate checks.
      write_prog(3'd0, make_instr(OP_ADD, 4'd3, 1'b0));
      write_prog(3'd1, make_instr(OP_ADD, 4'd5, 1'b1));
      exp_q.push_back({8'h08, 3'd1});
      start_run(1'b0);
      step();
      check("c1_busy", 32'(busy), 32'd1);
      check("c1_fetch_op", 32'(alu_op), 32'(OP_HOLD));
      step();
      check("c2_exec_op", 32'(alu_op), 32'(OP_ADD));
      check("c2_exec_a", 32'(alu_a), 32'd3);
      step();
      check("c3_acc", 32'(acc), 32'h03);
      check("c3_done", 32'(done), 32'd0);
      step();
      step();
      check("c5_acc", 32'(acc), 32'h08);
      check("c5_done", 32'(done), 32'd1);
      step();
      check("c6_busy", 32'(busy), 32'd0);
      check("c6_done", 32'(done), 32'd0);

      // Add then multiply; exactly two EXEC cycles.
      write_prog(3'd0, make_instr(OP_ADD, 4'd7, 1'b0));
      write_prog(3'd1, make_instr(OP_MUL, 4'd3, 1'b1));
      exp_q.push_back({8'h15, 3'd1});
      start_run(1'b0);
      exec_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (busy && alu_op != OP_HOLD) exec_cnt++;
         if (i == 3) check("mul_acc_c3", 32'(acc), 32'h07);
      end
      check("mul_exec_cycles", 32'(exec_cnt), 32'd2);

      // Full buffer, no last flag: stop at pc=7 and never refetch entry 0.
      for (int i = 0; i < 8; i++) write_prog(3'(i), make_instr(OP_ADD, 4'd1, 1'b0));
      exp_q.push_back({8'h08, 3'd7});
      start_run(1'b0);
      wait_done(1'b0, 40);
      for (int i = 0; i < 3; i++) begin
         step();
         check("full_post_busy", 32'(busy), 32'd0);
         check("full_post_pc", 32'(pc), 32'd7);
      end

      // Write while busy is dropped; a rerun still executes the original word.
      write_prog(3'd0, make_instr(OP_ADD, 4'd3, 1'b1));
      exp_q.push_back({8'h03, 3'd0});
      start_run(1'b0);
      write_prog(3'd0, 8'hFF);
      wait_done(1'b0, 20);
      exp_q.push_back({8'h03, 3'd0});
      start_run(1'b0);
      wait_done(1'b0, 20);

      // Reset during EXEC of the second instruction aborts silently.
      write_prog(3'd0, make_instr(OP_ADD, 4'd2, 1'b0));
      write_prog(3'd1, make_instr(OP_ADD, 4'd4, 1'b0));
      write_prog(3'd2, make_instr(OP_ADD, 4'd1, 1'b1));
      start_run(1'b0);
      step(); step(); step();
      @(posedge clk); #1 reset = 1'b1;
      step();
      check("abort_exec_a", 32'(alu_a), 32'd4);
      @(posedge clk); #1 reset = 1'b0;
      step();
      check("abort_acc", 32'(acc), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_pc", 32'(pc), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_no_done", 32'(done), 32'd0);
      end
      exp_q.push_back({8'h07, 3'd2});
      start_run(1'b0);
      wait_done(1'b0, 30);

      // Write and start in the same idle cycle: first fetch sees the new word.
      @(posedge clk); #1;
      prog_we = 1'b1; prog_addr = 3'd0; prog_data = make_instr(OP_ADD, 4'd5, 1'b1);
      start = 1'b1;
      exp_q.push_back({8'h05, 3'd0});
      @(posedge clk); #1;
      prog_we = 1'b0; start = 1'b0;
      wait_done(1'b0, 20);

      // start held through DONE relaunches once from the following idle cycle.
      write_prog(3'd0, make_instr(OP_ADD, 4'd1, 1'b1));
      exp_q.push_back({8'h01, 3'd0});
      exp_q.push_back({8'h01, 3'd0});
      @(posedge clk); #1 start = 1'b1;
      wait_done(1'b0, 20);
      step();
      check("held_idle_gap", 32'(busy), 32'd0);
      wait_done(1'b0, 20);
      start = 1'b0;
      step(); step();
      check("held_no_third", 32'(busy), 32'd0);

      // Accumulator retained across runs when clearing is disabled.
      write_prog(3'd0, make_instr(OP_ADD, 4'd8, 1'b1));
      exp_nc_q.push_back({8'h08, 3'd0});
      start_run(1'b1);
      wait_done(1'b1, 20);
      write_prog(3'd0, make_instr(OP_SHL, 4'd1, 1'b1));
      exp_nc_q.push_back({8'h10, 3'd0});
      start_run(1'b1);
      wait_done(1'b1, 20);

      repeat (3) step();
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("exp_nc_q_drained", 32'(exp_nc_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter PROG_DEPTH, default 8, program buffer entries; PC width is clog2(PROG_DEPTH).
REQ-002 Parameter CLEAR_ON_START, default 1; 1 = acc cleared to 0 when a run starts, 0 = acc retained.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 prog_we  in  1  program write strobe.
REQ-006 prog_addr  in  3  program buffer write address.
REQ-007 prog_data  in  8  instruction word: [7:5] op, [4:1] operand, [0] last flag.
REQ-008 start  in  1  run request, level-sampled.
REQ-009 alu_result  in  8  combinational result from the external ALU for the current alu_op/alu_a/acc.
REQ-010 alu_op  out  3  op select to the ALU.
REQ-011 alu_a  out  4  A operand to the ALU. The B operand is acc[3:0].
REQ-012 acc  out  8  accumulator register, fed back to the ALU.
REQ-013 pc  out  3  index of the instruction being fetched or executed.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle pulse at the end of a run.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, EXEC and DONE.
REQ-017 IDLE with start=1: go to FETCH; set pc=0; clear acc if CLEAR_ON_START=1.
REQ-018 FETCH: latch buffer[pc] into the instruction register (IR); go to EXEC.
REQ-019 EXEC: drive alu_op=IR.op and alu_a=IR.operand.
REQ-020 EXEC: at the closing edge, acc <= alu_result. This applies to every op, including op 111.
REQ-021 EXEC exit: if IR.last=1 or pc=PROG_DEPTH-1, go to DONE with pc held; otherwise pc <= pc+1 and go to FETCH. pc never wraps.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE. acc and pc hold their values until the next start.
REQ-023 Latency: 2 cycles per instruction. For an N-instruction run, done is high in cycle 2N+1 after the start-sampling edge.
REQ-024 Outside EXEC, alu_op=3'b111 and alu_a=0.
REQ-025 prog_we is honoured only in IDLE; writes while busy=1 are dropped.
REQ-026 prog_we and start in the same IDLE cycle: the write commits, and the first FETCH sees the new word.
REQ-027 start while busy=1 is ignored; no queuing.
REQ-028 start held high through DONE launches a new run from the following IDLE cycle.
REQ-029 The ALU is opaque to this block; no op decoding beyond forwarding is permitted.

Reset
REQ-030 reset=1 at a clock edge: state=IDLE, acc=0, pc=0, IR=0, done=0, busy=0. reset overrides start and prog_we.
REQ-031 Reset mid-run aborts the run with no done pulse.
REQ-032 Program buffer contents are not cleared by reset.

Structure
REQ-033 A shared package holds the state encoding, the instruction field positions/widths, and the op constants OP_ADD_RC=000 through OP_HOLD=111.
REQ-034 The program buffer is one sub-module, prog_buf: PROG_DEPTH x 8, one synchronous write port, asynchronous read.
REQ-035 The FSM, IR, pc and acc live in alu_sequencer.

Verification (bench ALU model: 001 A+B, 110 A*B, 101 acc<<A, 111 hold)
REQ-036 Program {001,a=3,last=0},{001,a=5,last=1}; pulse start:
- acc=0x03 after edge 2, acc=0x08 after edge 4.
- done high in cycle 5, busy low in cycle 6.
REQ-037 Program {001,a=7},{110,a=3,last=1}:
- acc=0x07, then 0x15.
- Only two EXEC cycles occur.
REQ-038 Eight entries, none with last set, all {001,a=1}:
- acc=0x08 and pc=7 at done.
- No FETCH of index 0 after the run.
REQ-039 During a run, prog_we to addr 0 with 0xFF, then start again:
- The write is dropped; the original word executes.
REQ-040 Assert reset in the EXEC of instruction 2:
- Next cycle acc=0, busy=0, no done pulse.
- A following start reruns the unchanged program.
REQ-041 CLEAR_ON_START=0 with acc=0x08; run {101,a=1,last=1}:
- acc=0x10.
